io_bus_bridge: RTL and testbench

- Memory-mapped peripheral slave on the CPU external data bus, downstream of the memory stage.
- Consumes the CPU's CS, WR_RD, ADDR and Data_BUS_WRITE; returns Data_BUS_READ in the same cycle, so the memory-stage mux can register it.
- Holds a transmit FIFO drained to an external device over a valid/ready handshake, a free-running cycle counter, a status register and a scratch register.

---
 rtl/io_bus_pkg.sv | 17 +
 rtl/io_tx_fifo.sv | 58 +++++
 rtl/io_bus_bridge.sv | 102 ++++++++++
 tb/tb_io_bus_bridge.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared register map and STATUS field layout for the CPU-side I/O bus bridge.
package io_bus_pkg;

    localparam int unsigned REG_SEL_W = 2;

    localparam logic [REG_SEL_W-1:0] REG_TXDATA  = 2'd0;
    localparam logic [REG_SEL_W-1:0] REG_STATUS  = 2'd1;
    localparam logic [REG_SEL_W-1:0] REG_CYCLE   = 2'd2;
    localparam logic [REG_SEL_W-1:0] REG_SCRATCH = 2'd3;

    localparam int unsigned EMPTY_BIT     = 0;
    localparam int unsigned FULL_BIT      = 1;
    localparam int unsigned OVF_BIT       = 2;
    localparam int unsigned COUNT_LSB     = 8;
    localparam int unsigned COUNT_FIELD_W = 8;

endpackage

// File: rtl/io_tx_fifo.sv
// First-word fall-through transmit FIFO; head word is presented straight from storage.
module io_tx_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       head_valid_c,
    output logic [DATA_W-1:0]          head_data_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Fullness/emptiness are judged on pre-edge state, so a push to a full FIFO drops even with a pop.
    assign full_c       = (count == CW'(DEPTH));
    assign empty_c      = (count == CW'(0));
    assign push_ok      = push && !full_c;
    assign pop_ok       = pop && !empty_c;
    assign head_valid_c = !empty_c;
    assign head_data_c  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_bus_bridge.sv
// Memory-mapped bridge: TX FIFO to an external device, cycle counter, status and scratch registers.
module io_bus_bridge
    import io_bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              CS,
    input  logic              WR_RD,
    input  logic [31:0]       ADDR,
    input  logic [DATA_W-1:0] Data_BUS_WRITE,
    output logic [DATA_W-1:0] Data_BUS_READ,
    output logic              dev_valid,
    output logic [DATA_W-1:0] dev_data,
    input  logic              dev_ready
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [REG_SEL_W-1:0] reg_sel;
    logic                 wr_en;
    logic                 rd_en;
    logic                 push;
    logic                 ovf_clr;
    logic                 cycle_wr;
    logic                 scratch_wr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 overflow;
    logic [DATA_W-1:0]    cycle;
    logic [DATA_W-1:0]    scratch;
    logic [DATA_W-1:0]    status_word;
    logic                 unused_addr_bits;

    assign reg_sel          = ADDR[3:2];
    assign unused_addr_bits = ^{ADDR[31:4], ADDR[1:0]};
    assign wr_en            = CS && WR_RD;
    assign rd_en            = CS && !WR_RD;
    assign push             = wr_en && (reg_sel == REG_TXDATA);
    assign ovf_clr          = wr_en && (reg_sel == REG_STATUS) && Data_BUS_WRITE[OVF_BIT];
    assign cycle_wr         = wr_en && (reg_sel == REG_CYCLE);
    assign scratch_wr       = wr_en && (reg_sel == REG_SCRATCH);

    io_tx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_tx_fifo (
        .clk          (CLK),
        .rst_n        (Rst),
        .push         (push),
        .pop          (dev_ready),
        .wdata        (Data_BUS_WRITE),
        .full_c       (fifo_full),
        .empty_c      (fifo_empty),
        .count        (fifo_count),
        .head_valid_c (dev_valid),
        .head_data_c  (dev_data)
    );

    // A TXDATA write and a STATUS write are exclusive, so set and clear never collide.
    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            overflow <= 1'b0;
            cycle    <= '0;
            scratch  <= '0;
        end else begin
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            cycle <= cycle_wr ? Data_BUS_WRITE : cycle + DATA_W'(1);
            if (scratch_wr) begin
                scratch <= Data_BUS_WRITE;
            end
        end
    end

    always_comb begin
        status_word                              = '0;
        status_word[EMPTY_BIT]                   = fifo_empty;
        status_word[FULL_BIT]                    = fifo_full;
        status_word[OVF_BIT]                     = overflow;
        status_word[COUNT_LSB +: COUNT_FIELD_W]  = COUNT_FIELD_W'(fifo_count);
    end

    // Combinational read path; the CPU memory stage registers it.
    always_comb begin
        Data_BUS_READ = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_STATUS:  Data_BUS_READ = status_word;
                REG_CYCLE:   Data_BUS_READ = cycle;
                REG_SCRATCH: Data_BUS_READ = scratch;
                default:     Data_BUS_READ = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed self-checking bench for io_bus_bridge with FIFO_DEPTH=8, DATA_W=32.
module tb_io_bus_bridge;

    logic        CLK;
    logic        Rst;
    logic        CS;
    logic        WR_RD;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        dev_valid;
    logic [31:0] dev_data;
    logic        dev_ready;

    int n_cmp = 0;
    int n_err = 0;

    io_bus_bridge #(
        .FIFO_DEPTH (8),
        .DATA_W     (32)
    ) dut (
        .CLK            (CLK),
        .Rst            (Rst),
        .CS             (CS),
        .WR_RD          (WR_RD),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .dev_valid      (dev_valid),
        .dev_data       (dev_data),
        .dev_ready      (dev_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        CS = 1'b1; WR_RD = 1'b1; ADDR = addr; Data_BUS_WRITE = data;
        tick();
        CS = 1'b0; WR_RD = 1'b0; ADDR = '0; Data_BUS_WRITE = '0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        CS = 1'b1; WR_RD = 1'b0; ADDR = addr;
        #1;
        chk(tag, Data_BUS_READ, exp);
        CS = 1'b0; ADDR = '0;
    endtask

    initial begin
        Rst = 1'b0; CS = 1'b0; WR_RD = 1'b0; ADDR = '0; Data_BUS_WRITE = '0; dev_ready = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_dev_valid", 32'(dev_valid), 32'h0);
        chk("rst_dev_data", dev_data, 32'h0);
        bus_read("rst_status", 32'h4, 32'h0000_0001);
        @(negedge CLK);
        Rst = 1'b1;
        repeat (5) tick();
        bus_read("cycle_after_5", 32'h8, 32'd5);
        bus_read("status_idle", 32'h4, 32'h0000_0001);
        bus_read("txdata_read_zero", 32'h0, 32'h0);

        // Scratch and read gating
        bus_write(32'hC, 32'hDEAD_BEEF);
        bus_read("scratch_rd", 32'hC, 32'hDEAD_BEEF);
        bus_read("scratch_rd_hi_addr_bits", 32'hFFFF_FFFC, 32'hDEAD_BEEF);
        CS = 1'b0; WR_RD = 1'b0; ADDR = 32'hC; #1;
        chk("cs0_read", Data_BUS_READ, 32'h0);
        CS = 1'b1; WR_RD = 1'b1; ADDR = 32'hC; #1;
        chk("write_cycle_read", Data_BUS_READ, 32'h0);
        CS = 1'b0; WR_RD = 1'b0; ADDR = '0;

        // Three-word push then drain
        bus_write(32'h0, 32'h11);
        chk("fwft_valid", 32'(dev_valid), 32'h1);
        chk("fwft_data", dev_data, 32'h11);
        bus_write(32'h0, 32'h22);
        bus_write(32'h0, 32'h33);
        bus_read("status_3", 32'h4, 32'h0000_0300);
        dev_ready = 1'b1;
        chk("drain_0", dev_data, 32'h11);
        tick();
        chk("drain_1", dev_data, 32'h22);
        tick();
        chk("drain_2", dev_data, 32'h33);
        tick();
        chk("drain_empty_valid", 32'(dev_valid), 32'h0);
        dev_ready = 1'b0;
        bus_read("status_drained", 32'h4, 32'h0000_0001);

        // Overflow: nine pushes into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) bus_write(32'h0, 32'(i));
        bus_read("status_ovf", 32'h4, 32'h0000_0806);
        bus_write(32'h4, 32'h0000_0004);
        bus_read("status_ovf_clr", 32'h4, 32'h0000_0802);
        dev_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf_drain_valid_%0d", i), 32'(dev_valid), 32'h1);
            chk($sformatf("ovf_drain_data_%0d", i), dev_data, 32'(i));
            tick();
        end
        chk("ovf_drain_done", 32'(dev_valid), 32'h0);
        dev_ready = 1'b0;

        // Push to full FIFO with simultaneous pop: pop happens, push dropped
        for (int i = 1; i <= 8; i++) bus_write(32'h0, 32'h100 + 32'(i));
        dev_ready = 1'b1;
        bus_write(32'h0, 32'hAA);
        dev_ready = 1'b0;
        bus_read("full_push_pop_status", 32'h4, 32'h0000_0704);
        chk("full_push_pop_head", dev_data, 32'h102);

        // Simultaneous push and pop in the middle: count holds
        bus_write(32'h4, 32'h0000_0004);
        dev_ready = 1'b1;
        bus_write(32'h0, 32'h55);
        dev_ready = 1'b0;
        bus_read("mid_push_pop_status", 32'h4, 32'h0000_0700);
        chk("mid_push_pop_head", dev_data, 32'h103);

        // Cycle write priority and wrap
        bus_write(32'h8, 32'hFFFF_FFFE);
        bus_read("cycle_load", 32'h8, 32'hFFFF_FFFE);
        tick();
        bus_read("cycle_max", 32'h8, 32'hFFFF_FFFF);
        tick();
        bus_read("cycle_wrap", 32'h8, 32'h0);

        // Reset with 4 words queued
        dev_ready = 1'b1;
        repeat (3) tick();
        dev_ready = 1'b0;
        bus_read("status_4_queued", 32'h4, 32'h0000_0400);
        chk("pre_reset_valid", 32'(dev_valid), 32'h1);
        #2;
        Rst = 1'b0;
        #1;
        chk("async_reset_valid", 32'(dev_valid), 32'h0);
        chk("async_reset_data", dev_data, 32'h0);
        @(negedge CLK);
        Rst = 1'b1;
        bus_read("status_after_reset", 32'h4, 32'h0000_0001);
        bus_read("scratch_after_reset", 32'hC, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
